// File: rtl/gmux_sel_ctrl.sv
// gmux_sel_ctrl
// Drives the select pin of a glitch-free clock mux (GMUX IS0) from an
// asynchronous enable request. The request is synchronised onto clk, a small
// FSM sequences the gate change, and the select is retimed onto the falling
// edge so the pin only moves while clk is low. A dwell counter enforces a
// minimum hold time on each select level.
//
// Ports
//   clk        in   source clock; the same net that feeds the GMUX clock pin
//   rstn       in   asynchronous active-low reset
//   en_req     in   asynchronous enable request level
//   force_off  in   clk-synchronous request to disable immediately (ignores dwell)
//   is0        out  select to the GMUX IS0 pin, launched on clk falling edge
//   en_ack     out  committed gate state, rising-edge domain
//   busy       out  a gate change is pending or the dwell is still running
//
// State      | Meaning
// -----------+---------------------------------------------------------------
// OFF        | gate closed; waits for req_s=1, force_off=0 and dwell expired
// TURN_ON    | gate bit just set; is0 rises on the coming falling edge
// ON         | gate open; leaves on force_off, or req_s=0 once dwell expired
// TURN_OFF   | gate bit just cleared; is0 falls on the coming falling edge
module gmux_sel_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DWELL   = 4,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_req,
    input  logic force_off,
    output logic is0,
    output logic en_ack,
    output logic busy
);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        TURN_ON  = 2'd1,
        ON       = 2'd2,
        TURN_OFF = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(MIN_DWELL);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   gate_q;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], en_req};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        case (state_q)
            OFF: begin
                if (req_s && !force_off && (cnt_q == '0)) begin
                    state_d = TURN_ON;
                end
            end
            TURN_ON: begin
                state_d = ON;
                cnt_d   = DWELL_LD;
            end
            ON: begin
                if (force_off || (!req_s && (cnt_q == '0))) begin
                    state_d = TURN_OFF;
                end
            end
            TURN_OFF: begin
                state_d = OFF;
                cnt_d   = DWELL_LD;
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    // gate and en_ack are registered from the next state so they line up
    // exactly with the state register: gate rises on entry to TURN_ON,
    // en_ack one edge later on entry to ON.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= OFF;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            en_ack  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= (state_d == TURN_ON) || (state_d == ON);
            en_ack  <= (state_d == ON) || (state_d == TURN_OFF);
        end
    end

    // Falling-edge retime keeps every is0 transition inside the clk-low phase.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            is0 <= 1'b0;
        end else begin
            is0 <= gate_q;
        end
    end

    // Built only from reset flops (and force_off, which is low-gated), so it
    // drops with rstn without needing its own register.
    assign busy = (state_q == TURN_ON) || (state_q == TURN_OFF) ||
                  (cnt_q != '0) || ((req_s != en_ack) && !force_off);

endmodule

// File: doc/gmux_sel_ctrl.md
GMUX_SEL_CTRL -- requirements
Module: gmux_sel_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of flops synchronising EN_REQ, legal range 2..4.
REQ-002 The block SHALL have parameter MIN_DWELL, default 4: minimum CLK cycles IS0 holds a level before it may change, legal range 0..15.
REQ-003 The block SHALL have parameter CNT_W, default 4: width of the dwell counter; MIN_DWELL SHALL fit in CNT_W bits.
REQ-004 The block SHALL have port CLK  input  1  source clock, the same net that drives the GMUX IC pin.
REQ-005 The block SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port EN_REQ  input  1  asynchronous clock-enable request level.
REQ-007 The block SHALL have port FORCE_OFF  input  1  CLK-synchronous immediate-disable request.
REQ-008 The block SHALL have port IS0  output  1  gate select to the GMUX IS0 pin, registered on CLK falling edge.
REQ-009 The block SHALL have port EN_ACK  output  1  registered copy of the committed gate state, rising-edge domain.
REQ-010 The block SHALL have port BUSY  output  1  high while a gate change is pending or dwell is running.

Function
REQ-011 The block SHALL pass EN_REQ through SYNC_STAGES rising-edge flops to produce req_s; no other logic SHALL use EN_REQ directly.
REQ-012 The block SHALL implement FSM states OFF, TURN_ON, ON, TURN_OFF, updated on CLK rising edge.
REQ-013 OFF -> TURN_ON SHALL occur when req_s=1, FORCE_OFF=0 and dwell counter=0; otherwise OFF is held.
REQ-014 TURN_ON SHALL last exactly one cycle, then go to ON unconditionally; TURN_OFF SHALL last exactly one cycle, then go to OFF unconditionally.
REQ-015 ON -> TURN_OFF SHALL occur when FORCE_OFF=1 (dwell ignored), or when req_s=0 and dwell counter=0.
REQ-016 An internal rising-edge gate bit SHALL be set on entry to TURN_ON and cleared on entry to TURN_OFF; IS0 SHALL capture it on the next CLK falling edge, so IS0 only changes while CLK is low.
REQ-017 EN_ACK SHALL be 1 in ON and TURN_OFF, and 0 in OFF and TURN_ON; it changes on the rising edge after IS0 changes.
REQ-018 The dwell counter SHALL load MIN_DWELL on entry to ON or OFF (from TURN_ON/TURN_OFF), decrement by 1 per cycle, and saturate at 0.
REQ-019 With MIN_DWELL=0 the block SHALL permit back-to-back transitions: IS0 stable for at least 2 cycles.
REQ-020 Latency: with EN_REQ rising before edge e0 and counter=0, the FSM SHALL enter TURN_ON at edge e0+SYNC_STAGES, IS0 SHALL rise at the following falling edge, and EN_ACK SHALL rise at edge e0+SYNC_STAGES+1.
REQ-021 FORCE_OFF=1 in TURN_ON SHALL NOT abort it; the FSM SHALL pass through ON for one cycle and then enter TURN_OFF.
REQ-022 EN_REQ pulses shorter than one CLK period MAY be lost; a pulse captured in req_s but dropped before the dwell ends SHALL NOT produce a transition.
REQ-023 BUSY SHALL be 1 when state is TURN_ON/TURN_OFF, when the dwell counter is nonzero, or when req_s differs from EN_ACK while FORCE_OFF=0.

Reset
REQ-024 RSTN=0 SHALL immediately clear the synchroniser, FSM (OFF), gate bit, dwell counter (0), IS0, EN_ACK and BUSY to 0, regardless of CLK.
REQ-025 Reset asserted while IS0=1 SHALL drop IS0 asynchronously; after release the block SHALL behave as from power-up, with enable permitted without dwell.
REQ-026 After RSTN deassertion, req_s SHALL be ignored until SYNC_STAGES rising edges have filled the synchroniser.

Verification
REQ-027 Defaults, EN_REQ 0->1 before edge 0 -> TURN_ON at edge 2, IS0=1 at the falling edge after edge 2, EN_ACK=1 at edge 3, BUSY=0 by edge 7.
REQ-028 EN_REQ toggled every cycle, MIN_DWELL=4 -> every IS0 level lasts >=6 cycles, and every IS0 edge coincides with CLK low.
REQ-029 ON with dwell=3, FORCE_OFF=1 for one cycle -> TURN_OFF on the next edge, IS0=0 at the next falling edge, and the dwell reloads to 4.
REQ-030 RSTN pulled low mid-cycle while IS0=1 -> IS0, EN_ACK and BUSY=0 within the reset propagation time; after release with EN_REQ=1, IS0=1 after SYNC_STAGES+0.5 cycles.
REQ-031 MIN_DWELL=0, EN_REQ 1->0->1 with 3-cycle spacing -> IS0 follows each change with a constant latency of SYNC_STAGES+0.5 cycles.
